// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter
// Shares the single main-memory port between icache refills (IF) and
// dcache refills/writebacks (MEM). Data side has priority; a streak
// counter lets a waiting instruction fetch win after MAX_DC_STREAK
// consecutive dcache grants. One line transaction is in flight at a time.
//
// Optional feature macro: SEGRE_ARB_PERF_EN
//   defined   -> if_wait_cnt_o / dc_wait_cnt_o are live 32-bit saturating
//                wait-cycle counters.
//   undefined -> both counter outputs are tied to 0 (no counter flops).
//
// Handshake: requests are levels held until the matching one-cycle ready
// pulse. The memory command (mem_rd_o / mem_wr_o) is held for the whole
// transaction and drops the cycle after the one-cycle mem_ready_i pulse,
// which is also the cycle the requester ready pulse and returned line
// appear. Requester inputs are not looked at while a transaction is busy.
//
// dbg_state_o exposes the FSM state (0 IDLE, 1 IF_RD, 2 DC_WR, 3 DC_RD).

module segre_mem_arbiter #(
    parameter int ADDR_SIZE     = 32,
    parameter int LINE_BYTES    = 16,
    parameter int MAX_DC_STREAK = 4
) (
    input  logic                      clk_i,
    input  logic                      rsn_i,
    // icache side
    input  logic                      if_mem_rd_i,
    input  logic [ADDR_SIZE-1:0]      if_mem_addr_i,
    output logic                      if_mem_ready_o,
    output logic [LINE_BYTES*8-1:0]   if_line_o,
    // dcache side
    input  logic                      dc_mem_rd_i,
    input  logic                      dc_mem_wr_i,
    input  logic [ADDR_SIZE-1:0]      dc_mem_addr_i,
    input  logic [LINE_BYTES*8-1:0]   dc_line_i,
    output logic                      dc_mem_ready_o,
    output logic [LINE_BYTES*8-1:0]   dc_line_o,
    // memory side
    output logic                      mem_rd_o,
    output logic                      mem_wr_o,
    output logic [ADDR_SIZE-1:0]      mem_addr_o,
    output logic [LINE_BYTES*8-1:0]   mem_line_o,
    input  logic                      mem_ready_i,
    input  logic [LINE_BYTES*8-1:0]   mem_line_i,
    // performance counters
    output logic [31:0]               if_wait_cnt_o,
    output logic [31:0]               dc_wait_cnt_o,
    // debug
    output logic [1:0]                dbg_state_o
);

    localparam int LINE_W   = LINE_BYTES * 8;
    localparam int OFF_BITS = $clog2(LINE_BYTES);
    localparam logic [ADDR_SIZE-1:0] ADDR_MASK =
        ~((ADDR_SIZE'(1) << OFF_BITS) - ADDR_SIZE'(1));
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DC_STREAK);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IF_RD = 2'd1,
        ST_DC_WR = 2'd2,
        ST_DC_RD = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_grant_if;
    logic                  w_grant_dc;
    logic                  w_starve;
    logic [3:0]            r_streak;
    logic [ADDR_SIZE-1:0]  r_addr;
    logic [LINE_W-1:0]     r_wdata;
    logic                  r_if_ready;
    logic                  r_dc_ready;
    logic [LINE_W-1:0]     r_if_line;
    logic [LINE_W-1:0]     r_dc_line;

    // State register; async reset aborts any in-flight command at once.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Arbitration in IDLE and completion detection while busy.
    always_comb begin
        w_next_state = r_state;
        w_grant_if   = 1'b0;
        w_grant_dc   = 1'b0;
        // IF has waited through too many dcache grants: it wins this round,
        // even over a writeback.
        w_starve     = if_mem_rd_i && (r_streak >= STREAK_MAX);
        case (r_state)
            ST_IDLE: begin
                if (dc_mem_wr_i && !w_starve) begin
                    w_next_state = ST_DC_WR;
                    w_grant_dc   = 1'b1;
                end else if (dc_mem_rd_i && !w_starve) begin
                    w_next_state = ST_DC_RD;
                    w_grant_dc   = 1'b1;
                end else if (if_mem_rd_i) begin
                    w_next_state = ST_IF_RD;
                    w_grant_if   = 1'b1;
                end
            end
            ST_IF_RD, ST_DC_WR, ST_DC_RD: begin
                if (mem_ready_i) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Memory command decoded from state so it is held for the whole transaction.
    always_comb begin
        mem_rd_o = (r_state == ST_IF_RD) || (r_state == ST_DC_RD);
        mem_wr_o = (r_state == ST_DC_WR);
    end

    // Count consecutive dcache grants while IF is waiting.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_streak <= 4'd0;
        end else if (!if_mem_rd_i || w_grant_if) begin
            r_streak <= 4'd0;
        end else if (w_grant_dc && (r_streak != 4'hF)) begin
            r_streak <= r_streak + 4'd1;
        end
    end

    // Capture line-aligned address and writeback data at grant time.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant_if) begin
            r_addr  <= if_mem_addr_i & ADDR_MASK;
        end else if (w_grant_dc) begin
            r_addr  <= dc_mem_addr_i & ADDR_MASK;
            if (w_next_state == ST_DC_WR) begin
                r_wdata <= dc_line_i;
            end
        end
    end

    // Register returned line and issue the requester ready pulse.
    // A writeback returns no data, so dc_line_o only updates on reads.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_if_ready <= 1'b0;
            r_dc_ready <= 1'b0;
            r_if_line  <= '0;
            r_dc_line  <= '0;
        end else begin
            r_if_ready <= 1'b0;
            r_dc_ready <= 1'b0;
            if (mem_ready_i) begin
                case (r_state)
                    ST_IF_RD: begin
                        r_if_ready <= 1'b1;
                        r_if_line  <= mem_line_i;
                    end
                    ST_DC_RD: begin
                        r_dc_ready <= 1'b1;
                        r_dc_line  <= mem_line_i;
                    end
                    ST_DC_WR: begin
                        r_dc_ready <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_addr_o     = r_addr;
    assign mem_line_o     = r_wdata;
    assign if_mem_ready_o = r_if_ready;
    assign dc_mem_ready_o = r_dc_ready;
    assign if_line_o      = r_if_line;
    assign dc_line_o      = r_dc_line;
    assign dbg_state_o    = r_state;

`ifdef SEGRE_ARB_PERF_EN
    logic [31:0] r_if_wait;
    logic [31:0] r_dc_wait;

    // Saturating counts of cycles each side waits for the memory port.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_if_wait <= '0;
            r_dc_wait <= '0;
        end else begin
            if (if_mem_rd_i && (r_state != ST_IF_RD) && (r_if_wait != 32'hFFFF_FFFF)) begin
                r_if_wait <= r_if_wait + 32'd1;
            end
            if ((dc_mem_rd_i || dc_mem_wr_i) && (r_state != ST_DC_RD) &&
                (r_state != ST_DC_WR) && (r_dc_wait != 32'hFFFF_FFFF)) begin
                r_dc_wait <= r_dc_wait + 32'd1;
            end
        end
    end

    assign if_wait_cnt_o = r_if_wait;
    assign dc_wait_cnt_o = r_dc_wait;
`else
    assign if_wait_cnt_o = 32'd0;
    assign dc_wait_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed bench for segre_mem_arbiter. Inputs change 1 time unit after a
// rising edge and outputs are sampled at that same point, so "cycle n"
// below is the interval starting just after rising edge n.
module tb_segre_mem_arbiter;

  logic         clk_i;
  logic         rsn_i;
  logic         if_mem_rd_i;
  logic [31:0]  if_mem_addr_i;
  logic         if_mem_ready_o;
  logic [127:0] if_line_o;
  logic         dc_mem_rd_i;
  logic         dc_mem_wr_i;
  logic [31:0]  dc_mem_addr_i;
  logic [127:0] dc_line_i;
  logic         dc_mem_ready_o;
  logic [127:0] dc_line_o;
  logic         mem_rd_o;
  logic         mem_wr_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_line_o;
  logic         mem_ready_i;
  logic [127:0] mem_line_i;
  logic [31:0]  if_wait_cnt_o;
  logic [31:0]  dc_wait_cnt_o;
  logic [1:0]   dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IFRD = 2'd1;
  localparam logic [1:0] S_DCWR = 2'd2;
  localparam logic [1:0] S_DCRD = 2'd3;

`ifdef SEGRE_ARB_PERF_EN
  localparam logic [31:0] EXP_IF_WAIT_MID = 32'd5;
  localparam logic [31:0] EXP_IF_WAIT     = 32'd6;
  localparam logic [31:0] EXP_DC_WAIT     = 32'd1;
`else
  localparam logic [31:0] EXP_IF_WAIT_MID = 32'd0;
  localparam logic [31:0] EXP_IF_WAIT     = 32'd0;
  localparam logic [31:0] EXP_DC_WAIT     = 32'd0;
`endif

  segre_mem_arbiter #(
    .ADDR_SIZE    (32),
    .LINE_BYTES   (16),
    .MAX_DC_STREAK(4)
  ) dut (
    .clk_i         (clk_i),
    .rsn_i         (rsn_i),
    .if_mem_rd_i   (if_mem_rd_i),
    .if_mem_addr_i (if_mem_addr_i),
    .if_mem_ready_o(if_mem_ready_o),
    .if_line_o     (if_line_o),
    .dc_mem_rd_i   (dc_mem_rd_i),
    .dc_mem_wr_i   (dc_mem_wr_i),
    .dc_mem_addr_i (dc_mem_addr_i),
    .dc_line_i     (dc_line_i),
    .dc_mem_ready_o(dc_mem_ready_o),
    .dc_line_o     (dc_line_o),
    .mem_rd_o      (mem_rd_o),
    .mem_wr_o      (mem_wr_o),
    .mem_addr_o    (mem_addr_o),
    .mem_line_o    (mem_line_o),
    .mem_ready_i   (mem_ready_i),
    .mem_line_i    (mem_line_i),
    .if_wait_cnt_o (if_wait_cnt_o),
    .dc_wait_cnt_o (dc_wait_cnt_o),
    .dbg_state_o   (dbg_state_o)
  );

  // clock / reset block
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Memory responder: called in the first command cycle; checks the held
  // command for lat cycles, returns mem_ready_i in the last one, then checks
  // the requester pulse in the following cycle (where it returns).
  task automatic serve(input string tag, input logic exp_wr, input logic [31:0] exp_addr,
                       input logic [127:0] exp_wdata, input int lat,
                       input logic [127:0] rline, input logic to_if);
    for (int i = 1; i <= lat; i++) begin
      check({tag, "_rd"}, mem_rd_o, !exp_wr);
      check({tag, "_wr"}, mem_wr_o, exp_wr);
      check({tag, "_addr"}, mem_addr_o, exp_addr);
      if (exp_wr) check({tag, "_wdata"}, mem_line_o, exp_wdata);
      if (i == lat) begin
        mem_ready_i = 1'b1;
        mem_line_i  = rline;
      end
      tick();
    end
    mem_ready_i = 1'b0;
    mem_line_i  = {4{$urandom}};
    check({tag, "_if_rdy"}, if_mem_ready_o, to_if);
    check({tag, "_dc_rdy"}, dc_mem_ready_o, !to_if);
    check({tag, "_cmd_off"}, {mem_rd_o, mem_wr_o}, 2'b00);
    check({tag, "_idle"}, dbg_state_o, S_IDLE);
    if (to_if) check({tag, "_if_line"}, if_line_o, rline);
    else if (!exp_wr) check({tag, "_dc_line"}, dc_line_o, rline);
  endtask

  initial begin
    logic [127:0] l_a;
    logic [127:0] l_b;
    logic [127:0] l_w;
    logic [127:0] prev_if_line;
    logic         order_is_if [6];

    rsn_i = 1'b0;
    if_mem_rd_i = 1'b0;
    if_mem_addr_i = '0;
    dc_mem_rd_i = 1'b0;
    dc_mem_wr_i = 1'b0;
    dc_mem_addr_i = '0;
    dc_line_i = '0;
    mem_ready_i = 1'b0;
    mem_line_i = '0;

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_state", dbg_state_o, S_IDLE);
    check("rst_cmd", {mem_rd_o, mem_wr_o}, 2'b00);
    check("rst_rdy", {if_mem_ready_o, dc_mem_ready_o}, 2'b00);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_wline", mem_line_o, 128'd0);
    check("rst_if_line", if_line_o, 128'd0);
    check("rst_dc_line", dc_line_o, 128'd0);
    check("rst_if_cnt", if_wait_cnt_o, 32'd0);
    check("rst_dc_cnt", dc_wait_cnt_o, 32'd0);
    rsn_i = 1'b1;
    tick();

    // IF-only read at 0x1004, memory ready 3 cycles after command
    l_a = {4{$urandom}};
    if_mem_rd_i = 1'b1;
    if_mem_addr_i = 32'h0000_1004;
    tick();
    check("t1_state", dbg_state_o, S_IFRD);
    if_mem_addr_i = 32'hDEAD_BEEF;  // ignored while busy
    serve("t1", 1'b0, 32'h0000_1000, '0, 4, l_a, 1'b1);
    if_mem_rd_i = 1'b0;
    tick();
    check("t1_pulse_once", if_mem_ready_o, 1'b0);
    check("t1_no_regrant", mem_rd_o, 1'b0);

    // writeback and refill together: writeback first, then refill
    l_w = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    l_b = {4{$urandom}};
    dc_mem_wr_i = 1'b1;
    dc_mem_rd_i = 1'b1;
    dc_mem_addr_i = 32'h0000_2000;
    dc_line_i = l_w;
    tick();
    check("t2_state_wr", dbg_state_o, S_DCWR);
    serve("t2_wb", 1'b1, 32'h0000_2000, l_w, 1, '0, 1'b0);
    dc_mem_wr_i = 1'b0;
    tick();
    check("t2_state_rd", dbg_state_o, S_DCRD);
    serve("t2_rf", 1'b0, 32'h0000_2000, '0, 2, l_b, 1'b0);
    dc_mem_rd_i = 1'b0;
    check("t2_if_line_hold", if_line_o, l_a);
    tick();

    // streak guard: expected grant order DC DC DC DC IF DC
    order_is_if = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    if_mem_rd_i = 1'b1;
    if_mem_addr_i = 32'h0000_3008;
    dc_mem_rd_i = 1'b1;
    dc_mem_addr_i = 32'h0000_400C;
    prev_if_line = l_a;
    for (int g = 0; g < 6; g++) begin
      tick();
      l_b = {4{$urandom}};
      if (order_is_if[g]) begin
        serve($sformatf("t3_g%0d_if", g), 1'b0, 32'h0000_3000, '0, 1, l_b, 1'b1);
        if_mem_rd_i = 1'b0;
        prev_if_line = l_b;
      end else begin
        serve($sformatf("t3_g%0d_dc", g), 1'b0, 32'h0000_4000, '0, 1, l_b, 1'b0);
        check($sformatf("t3_g%0d_if_line_hold", g), if_line_o, prev_if_line);
      end
    end
    dc_mem_rd_i = 1'b0;
    tick();
    check("t3_end_idle", dbg_state_o, S_IDLE);

    // IF request withdrawn one cycle after grant
    l_a = {4{$urandom}};
    if_mem_rd_i = 1'b1;
    if_mem_addr_i = 32'h0000_5008;
    tick();
    if_mem_rd_i = 1'b0;
    serve("t4", 1'b0, 32'h0000_5000, '0, 2, l_a, 1'b1);
    tick();
    check("t4_idle", dbg_state_o, S_IDLE);
    check("t4_pulse_once", if_mem_ready_o, 1'b0);
    // stray memory ready in IDLE is ignored
    mem_ready_i = 1'b1;
    mem_line_i = {4{$urandom}};
    tick();
    mem_ready_i = 1'b0;
    check("t4_stray_rdy", {if_mem_ready_o, dc_mem_ready_o}, 2'b00);
    check("t4_stray_line", if_line_o, l_a);
    check("t4_stray_state", dbg_state_o, S_IDLE);

    // reset asserted while in DC_RD
    dc_mem_rd_i = 1'b1;
    dc_mem_addr_i = 32'h0000_6000;
    tick();
    check("t5_busy", mem_rd_o, 1'b1);
    tick();
    rsn_i = 1'b0;
    dc_mem_rd_i = 1'b0;
    #1;
    check("t5_rd_drop", mem_rd_o, 1'b0);
    check("t5_state", dbg_state_o, S_IDLE);
    check("t5_addr", mem_addr_o, 32'd0);
    tick();
    tick();
    rsn_i = 1'b1;
    tick();
    check("t5_no_rdy", {if_mem_ready_o, dc_mem_ready_o}, 2'b00);
    check("t5_idle", dbg_state_o, S_IDLE);
    check("t5_cmd", {mem_rd_o, mem_wr_o}, 2'b00);

    // IF waits 6 cycles behind a dcache read
    if_mem_rd_i = 1'b1;
    if_mem_addr_i = 32'h0000_7000;
    dc_mem_rd_i = 1'b1;
    dc_mem_addr_i = 32'h0000_8000;
    tick();
    serve("t6_dc", 1'b0, 32'h0000_8000, '0, 4, {4{$urandom}}, 1'b0);
    dc_mem_rd_i = 1'b0;
    check("t6_if_wait_mid", if_wait_cnt_o, EXP_IF_WAIT_MID);
    tick();
    serve("t6_if", 1'b0, 32'h0000_7000, '0, 1, {4{$urandom}}, 1'b1);
    if_mem_rd_i = 1'b0;
    check("t6_if_wait", if_wait_cnt_o, EXP_IF_WAIT);
    check("t6_dc_wait", dc_wait_cnt_o, EXP_DC_WAIT);
    tick();
    tick();
    check("t6_if_wait_hold", if_wait_cnt_o, EXP_IF_WAIT);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Protocol invariants checked every cycle.
  always @(negedge clk_i) begin
    if (rsn_i) begin
      if (mem_rd_o && mem_wr_o) check("inv_rd_wr", {mem_rd_o, mem_wr_o}, 2'b10);
      if (if_mem_ready_o && dc_mem_ready_o) check("inv_rdy", {if_mem_ready_o, dc_mem_ready_o}, 2'b10);
    end
  end

endmodule
